// File: rtl/batch_error_stage.sv
// Batched Q-format error stage: accumulates (expected - out) over a batch
// and hands the saturated floor-mean to the neuron under valid/ready.
module batch_error_stage #(
    parameter int WIDTH      = 32,
    parameter int BATCH_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic signed [WIDTH-1:0] expected,
    input  logic signed [WIDTH-1:0] out,
    output logic                    err_valid,
    input  logic                    err_ready,
    output logic signed [WIDTH-1:0] backpropStart,
    output logic [BATCH_LOG2:0]     sample_count
);

    localparam int ACC_W = WIDTH + BATCH_LOG2 + 1;
    localparam int HI_W  = ACC_W - WIDTH + 1;

    localparam logic [BATCH_LOG2:0] LAST_IDX =
        (BATCH_LOG2+1)'((1 << BATCH_LOG2) - 1);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [ACC_W-1:0] r_acc;
    logic [BATCH_LOG2:0]     r_count;
    logic [WIDTH-1:0]        r_bp;

    logic signed [WIDTH:0]   w_diff;
    logic signed [ACC_W-1:0] w_diff_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_mean;
    logic [HI_W-1:0]         w_mean_hi;
    logic                    w_fits;
    logic [WIDTH-1:0]        w_sat;
    logic                    w_accept;
    logic                    w_last;

    // Full-precision difference and running sum, so nothing wraps before the mean
    always_comb begin
        w_diff     = {expected[WIDTH-1], expected} - {out[WIDTH-1], out};
        w_diff_ext = {{(ACC_W-WIDTH-1){w_diff[WIDTH]}}, w_diff};
        w_sum      = r_acc + w_diff_ext;
        w_mean     = w_sum >>> BATCH_LOG2;
        w_mean_hi  = w_mean[ACC_W-1:WIDTH-1];
        w_fits     = (w_mean_hi == '0) || (w_mean_hi == '1);
        if (w_fits) begin
            w_sat = w_mean[WIDTH-1:0];
        end else if (w_mean[ACC_W-1]) begin
            w_sat = SAT_MIN;
        end else begin
            w_sat = SAT_MAX;
        end
    end

    assign w_accept = sample_valid && sample_ready;
    assign w_last   = (r_count == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: batch completion enters HOLD, handshake releases it
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ACCUM: if (w_accept && w_last) w_state_nxt = HOLD;
            HOLD:  if (err_ready)          w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Outputs decoded from state; ready also masked by reset
    always_comb begin
        sample_ready = (r_state == ACCUM) && !rst;
        err_valid    = (r_state == HOLD);
    end

    // Accumulator, sample counter and held result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_bp    <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_acc   <= '0;
                r_count <= '0;
                r_bp    <= w_sat;
            end else begin
                r_acc   <= w_sum;
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign backpropStart = r_bp;
    assign sample_count  = r_count;

endmodule

// File: tb/tb_batch_error_stage.sv
// Randomised self-checking bench for batch_error_stage against a
// plain-arithmetic batch-mean model.
module tb_batch_error_stage;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] expected;
    logic [31:0] out_s;
    logic        err_valid;
    logic        err_ready;
    logic [31:0] backpropStart;
    logic [3:0]  sample_count;

    int checks;
    int failures;

    batch_error_stage #(.WIDTH(32), .BATCH_LOG2(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .expected     (expected),
        .out          (out_s),
        .err_valid    (err_valid),
        .err_ready    (err_ready),
        .backpropStart(backpropStart),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed difference as an ordinary integer
    function automatic longint dif(input logic [31:0] e, input logic [31:0] o);
        longint a;
        longint b;
        a = longint'($signed(e));
        b = longint'($signed(o));
        return a - b;
    endfunction

    // Reference: floor mean of 8 then clamp to the 32-bit signed range
    function automatic logic [31:0] ref_mean(input longint sum);
        longint m;
        m = sum >>> 3;
        if (m > 64'sh000000007FFFFFFF) return 32'h7FFFFFFF;
        if (m < -64'sh0000000080000000) return 32'h80000000;
        return 32'(m);
    endfunction

    task automatic send(input logic [31:0] e, input logic [31:0] o);
        int n;
        n = 0;
        while (sample_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sample_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout sample_ready=%b required=1", sample_ready);
        end
        sample_valid = 1'b1;
        expected     = e;
        out_s        = o;
        @(negedge clk);
        sample_valid = 1'b0;
        expected     = $urandom;
        out_s        = $urandom;
    endtask

    task automatic ack();
        err_ready = 1'b1;
        @(negedge clk);
        err_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sample_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_in_rst got=%b required=0", sample_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sample_ready !== 1'b1 || err_valid !== 1'b0 ||
            backpropStart !== 32'h0 || sample_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b ev=%b bp=%h cnt=%0d required 1 0 0 0",
                     sample_ready, err_valid, backpropStart, sample_count);
        end
    endtask

    task automatic test_basic_mean();
        longint sum;
        logic [3:0] want_cnt;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'h00010000, 32'h0);
            sum += dif(32'h00010000, 32'h0);
            want_cnt = (i < 7) ? 4'(i + 1) : 4'd0;
            checks++;
            if (sample_count !== want_cnt) begin
                failures++;
                $display("FAIL basic_count[%0d] got=%0d required=%0d",
                         i, sample_count, want_cnt);
            end
        end
        checks++;
        if (err_valid !== 1'b1 || backpropStart !== ref_mean(sum) ||
            sample_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_mean got ev=%b bp=%h rdy=%b required 1 %h 0",
                     err_valid, backpropStart, sample_ready, ref_mean(sum));
        end
        ack();
        checks++;
        if (err_valid !== 1'b0 || sample_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ack got ev=%b rdy=%b required 0 1",
                     err_valid, sample_ready);
        end
    endtask

    task automatic test_floor();
        longint sum;
        logic [31:0] v;
        sum = 0;
        for (int i = 0; i < 7; i++) begin
            v = $urandom;
            send(v, v);
            sum += dif(v, v);
        end
        send(32'h0, 32'h1);
        sum += dif(32'h0, 32'h1);
        checks++;
        if (err_valid !== 1'b1 || backpropStart !== ref_mean(sum)) begin
            failures++;
            $display("FAIL floor_neg got ev=%b bp=%h required 1 %h",
                     err_valid, backpropStart, ref_mean(sum));
        end
        ack();
        sum = 0;
        for (int i = 0; i < 7; i++) begin
            v = $urandom_range(0, 32'h0FFFFFFF);
            send(v + 32'h1, v);
            sum += dif(v + 32'h1, v);
        end
        send(32'h1234, 32'h1234);
        checks++;
        if (err_valid !== 1'b1 || backpropStart !== ref_mean(sum)) begin
            failures++;
            $display("FAIL floor_pos got ev=%b bp=%h required 1 %h",
                     err_valid, backpropStart, ref_mean(sum));
        end
        ack();
    endtask

    task automatic test_saturation();
        longint sum;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'h7FFFFFFF, 32'h80000000);
            sum += dif(32'h7FFFFFFF, 32'h80000000);
        end
        checks++;
        if (backpropStart !== ref_mean(sum)) begin
            failures++;
            $display("FAIL sat_pos got=%h required=%h", backpropStart, ref_mean(sum));
        end
        ack();
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'h80000000, 32'h7FFFFFFF);
            sum += dif(32'h80000000, 32'h7FFFFFFF);
        end
        checks++;
        if (backpropStart !== ref_mean(sum)) begin
            failures++;
            $display("FAIL sat_neg got=%h required=%h", backpropStart, ref_mean(sum));
        end
        ack();
    endtask

    task automatic test_backpressure();
        longint sum;
        logic [31:0] e;
        logic [31:0] o;
        logic [31:0] held;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            e = $urandom;
            o = $urandom;
            send(e, o);
            sum += dif(e, o);
        end
        held = ref_mean(sum);
        checks++;
        if (err_valid !== 1'b1 || backpropStart !== held) begin
            failures++;
            $display("FAIL bp_first got ev=%b bp=%h required 1 %h",
                     err_valid, backpropStart, held);
        end
        for (int c = 0; c < 5; c++) begin
            sample_valid = 1'b1;
            expected     = $urandom;
            out_s        = $urandom;
            @(negedge clk);
            checks++;
            if (err_valid !== 1'b1 || backpropStart !== held ||
                sample_ready !== 1'b0 || sample_count !== 4'd0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got ev=%b bp=%h rdy=%b cnt=%0d required 1 %h 0 0",
                         c, err_valid, backpropStart, sample_ready, sample_count, held);
            end
        end
        sample_valid = 1'b0;
        ack();
        checks++;
        if (err_valid !== 1'b0 || sample_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got ev=%b rdy=%b required 0 1",
                     err_valid, sample_ready);
        end
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            e = $urandom;
            o = $urandom;
            send(e, o);
            sum += dif(e, o);
        end
        checks++;
        if (err_valid !== 1'b1 || backpropStart !== ref_mean(sum)) begin
            failures++;
            $display("FAIL bp_next got ev=%b bp=%h required 1 %h",
                     err_valid, backpropStart, ref_mean(sum));
        end
        ack();
    endtask

    task automatic test_reset_mid_batch();
        longint sum;
        logic [31:0] o;
        for (int i = 0; i < 5; i++) begin
            o = $urandom_range(0, 32'h00FFFFFF);
            send(o + 32'h00100000, o);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (sample_count !== 4'd0 || err_valid !== 1'b0 || sample_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid got cnt=%0d ev=%b rdy=%b required 0 0 1",
                     sample_count, err_valid, sample_ready);
        end
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            o = $urandom_range(0, 32'h00FFFFFF);
            send(o + 32'h00010000, o);
            sum += dif(o + 32'h00010000, o);
        end
        checks++;
        if (backpropStart !== ref_mean(sum) || backpropStart !== 32'h00010000) begin
            failures++;
            $display("FAIL rst_mid_mean got=%h required=%h", backpropStart, ref_mean(sum));
        end
        ack();
    endtask

    task automatic test_bubbles();
        longint sum;
        logic [31:0] e;
        logic [31:0] o;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (err_valid !== 1'b0) begin
                failures++;
                $display("FAIL bubble_early[%0d] ev=%b required 0", i, err_valid);
            end
            e = $urandom;
            o = $urandom;
            send(e, o);
            sum += dif(e, o);
        end
        checks++;
        if (err_valid !== 1'b1 || backpropStart !== ref_mean(sum)) begin
            failures++;
            $display("FAIL bubble_mean got ev=%b bp=%h required 1 %h",
                     err_valid, backpropStart, ref_mean(sum));
        end
        ack();
    endtask

    task automatic test_back_to_back();
        longint sum;
        logic [31:0] e;
        logic [31:0] o;
        err_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            sum = 0;
            for (int i = 0; i < 8; i++) begin
                e = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
                o = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
                send(e, o);
                sum += dif(e, o);
            end
            checks++;
            if (err_valid !== 1'b1 || backpropStart !== ref_mean(sum)) begin
                failures++;
                $display("FAIL b2b[%0d] got ev=%b bp=%h required 1 %h",
                         b, err_valid, backpropStart, ref_mean(sum));
            end
            @(negedge clk);
            checks++;
            if (err_valid !== 1'b0 || sample_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_bubble[%0d] got ev=%b rdy=%b required 0 1",
                         b, err_valid, sample_ready);
            end
        end
        err_ready = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        sample_valid = 1'b0;
        expected     = '0;
        out_s        = '0;
        err_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_mean();
        test_floor();
        test_saturation();
        test_backpressure();
        test_reset_mid_batch();
        test_bubbles();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
